skid_buffer: RTL and testbench

- Two-entry, fully registered ready/valid pipeline stage.
- Every output is a flop, including `ready_o`. This breaks the combinational `ready_i`→`ready_o` path that a single-register elastic stage leaves open.
- Sustains one transfer per cycle. A second "skid" register absorbs the beat already in flight when the consumer stalls.
- Placement: between long-haul stages of the Sobel datapath (line buffer → window → gradient) wherever backpressure timing closes poorly.

---
 rtl/skid_buffer_if.sv | 23 ++
 rtl/skid_buffer.sv | 99 +++++++++
 tb/tb_skid_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/skid_buffer_if.sv
// Ready/valid handshake bundle for skid_buffer: upstream payload, downstream payload and occupancy.
// The slave modport is the buffer side; the master modport drives the buffer.
interface skid_buffer_if #(
   parameter int unsigned WIDTH_P = 8
);
   logic [WIDTH_P-1:0] data_i;
   logic               valid_i;
   logic               ready_o;
   logic               valid_o;
   logic [WIDTH_P-1:0] data_o;
   logic               ready_i;
   logic [1:0]         count_o;

   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, valid_o, data_o, count_o
   );

   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, valid_o, data_o, count_o
   );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry fully registered ready/valid stage (main + skid register); every output is a flop.
// Optional SKID_BUFFER_FLUSH_EN adds flush_i, which empties the buffer and drops the offered beat.
module skid_buffer #(
   parameter int unsigned WIDTH_P = 8
) (
   input logic          clk_i,
   input logic          rstn_i,
`ifdef SKID_BUFFER_FLUSH_EN
   input logic          flush_i,
`endif
   skid_buffer_if.slave bus_if
);

   typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

   state_e             r_state;
   state_e             w_state_next;
   logic [WIDTH_P-1:0] r_main;
   logic [WIDTH_P-1:0] r_skid;
   logic [WIDTH_P-1:0] w_main_d;
   logic [WIDTH_P-1:0] w_skid_d;
   logic               r_ready;
   logic               r_valid;
   logic [1:0]         r_count;
   logic [1:0]         w_count_d;
   logic               w_in_fire;

   // Gate with the registered ready so the edge right after reset accepts nothing.
   assign w_in_fire = bus_if.valid_i & r_ready;

   always_comb begin
      w_state_next = r_state;
      w_main_d     = r_main;
      w_skid_d     = r_skid;
      w_count_d    = 2'd0;
      unique case (r_state)
         StEmpty: begin
            if (w_in_fire) begin
               w_main_d     = bus_if.data_i;
               w_state_next = StBusy;
            end
         end
         StBusy: begin
            if (w_in_fire && bus_if.ready_i) begin
               w_main_d = bus_if.data_i;
            end else if (w_in_fire) begin
               w_skid_d     = bus_if.data_i;
               w_state_next = StFull;
            end else if (bus_if.ready_i) begin
               w_state_next = StEmpty;
            end
         end
         StFull: begin
            if (bus_if.ready_i) begin
               w_main_d     = r_skid;
               w_state_next = StBusy;
            end
         end
         default: w_state_next = StEmpty;
      endcase
`ifdef SKID_BUFFER_FLUSH_EN
      // Flush wins over any transfer; data registers keep their contents.
      if (flush_i) begin
         w_state_next = StEmpty;
         w_main_d     = r_main;
         w_skid_d     = r_skid;
      end
`endif
      unique case (w_state_next)
         StBusy:  w_count_d = 2'd1;
         StFull:  w_count_d = 2'd2;
         default: w_count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state <= StEmpty;
         r_main  <= '0;
         r_skid  <= '0;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
         r_count <= 2'd0;
      end else begin
         r_state <= w_state_next;
         r_main  <= w_main_d;
         r_skid  <= w_skid_d;
         r_ready <= (w_state_next != StFull);
         r_valid <= (w_state_next != StEmpty);
         r_count <= w_count_d;
      end
   end

   assign bus_if.ready_o = r_ready;
   assign bus_if.valid_o = r_valid;
   assign bus_if.data_o  = r_main;
   assign bus_if.count_o = r_count;

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed steps plus random traffic against a queue model.
// Flush steps are built only with SKID_BUFFER_FLUSH_EN.
module tb_skid_buffer;

   logic       clk;
   logic       rstn;
   logic       valid;
   logic       rdy;
   logic       flush;
   logic [7:0] data;

   int total = 0;
   int bad   = 0;

   skid_buffer_if #(.WIDTH_P(8)) bus ();

   assign bus.data_i  = data;
   assign bus.valid_i = valid;
   assign bus.ready_i = rdy;

   skid_buffer #(.WIDTH_P(8)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
`ifdef SKID_BUFFER_FLUSH_EN
      .flush_i(flush),
`endif
      .bus_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: contents of the buffer, oldest first.
   logic [7:0] q[$];
   logic [7:0] m_last  = 8'h00;
   logic       m_ready = 1'b0;
   int         dut_sent = 0;
   int         dut_recv = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic       prev_valid;
      logic       prev_rdy;
      logic [7:0] prev_data;
      logic       stall;
      prev_valid = bus.valid_o;
      prev_rdy   = rdy;
      prev_data  = bus.data_o;
      stall      = rstn && !flush && prev_valid && !prev_rdy;
      if (rstn && !flush && valid && bus.ready_o) dut_sent++;
      if (rstn && !flush && bus.valid_o && rdy) dut_recv++;
      @(posedge clk);
      if (!rstn) begin
         q.delete();
         m_last  = 8'h00;
         m_ready = 1'b0;
      end else if (flush) begin
         q.delete();
         m_ready = 1'b1;
      end else begin
         logic in_fire;
         in_fire = valid && m_ready;
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (in_fire) q.push_back(data);
         m_ready = (q.size() < 2);
      end
      if (q.size() > 0) m_last = q[0];
      #1;
      chk("valid_o", 32'(bus.valid_o), 32'(q.size() > 0));
      chk("ready_o", 32'(bus.ready_o), 32'(m_ready));
      chk("count_o", 32'(bus.count_o), 32'(q.size()));
      chk("data_o", 32'(bus.data_o), 32'(m_last));
      if (rstn) chk("ready_vs_count", 32'(!bus.ready_o), 32'(bus.count_o == 2'd2));
      if (stall) chk("data_stable", 32'(bus.data_o), 32'(prev_data));
   endtask

   initial begin
      rstn  = 1'b0;
      valid = 1'b1;
      rdy   = 1'b0;
      flush = 1'b0;
      data  = 8'hAA;

      // Reset with a beat offered: nothing is latched, ready_o stays low.
      repeat (3) begin
         step();
         chk("rst_valid", 32'(bus.valid_o), 32'd0);
         chk("rst_ready", 32'(bus.ready_o), 32'd0);
         chk("rst_data", 32'(bus.data_o), 32'd0);
      end
      rstn = 1'b1;
      step();
      chk("rel_ready", 32'(bus.ready_o), 32'd1);
      chk("rel_count", 32'(bus.count_o), 32'd0);
      valid = 1'b0;

      // Streaming with ready_i high: one cycle latency, no bubbles.
      rdy = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         valid = 1'b1;
         data  = 8'(i);
         step();
         chk("stream_data", 32'(bus.data_o), 32'(i));
         chk("stream_count", 32'(bus.count_o), 32'd1);
      end
      valid = 1'b0;
      step();
      chk("stream_drain", 32'(bus.valid_o), 32'd0);

      // Stall: 0x20 presented, ready_i drops while 0x21 arrives.
      valid = 1'b1;
      data  = 8'h20;
      step();
      rdy  = 1'b0;
      data = 8'h21;
      step();
      chk("stall_count", 32'(bus.count_o), 32'd2);
      chk("stall_ready", 32'(bus.ready_o), 32'd0);
      chk("stall_data", 32'(bus.data_o), 32'h20);
      data = 8'h22;
      step();
      chk("stall_hold", 32'(bus.data_o), 32'h20);
      rdy = 1'b1;
      step();
      chk("refill_data", 32'(bus.data_o), 32'h21);
      chk("refill_ready", 32'(bus.ready_o), 32'd1);
      step();
      valid = 1'b0;
      chk("refill_next", 32'(bus.data_o), 32'h22);
      step();
      chk("refill_empty", 32'(bus.valid_o), 32'd0);

      // Mid-traffic reset while FULL with 0x30/0x31.
      valid = 1'b1;
      data  = 8'h30;
      step();
      rdy  = 1'b0;
      data = 8'h31;
      step();
      chk("pre_rst_count", 32'(bus.count_o), 32'd2);
      valid = 1'b0;
      rstn  = 1'b0;
      step();
      chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
      chk("mid_rst_count", 32'(bus.count_o), 32'd0);
      rstn = 1'b1;
      rdy  = 1'b1;
      repeat (3) begin
         step();
         chk("mid_rst_silent", 32'(bus.valid_o), 32'd0);
      end

`ifdef SKID_BUFFER_FLUSH_EN
      // Flush while FULL with 0x40/0x41 and 0x42 offered.
      valid = 1'b1;
      data  = 8'h40;
      step();
      rdy  = 1'b0;
      data = 8'h41;
      step();
      flush = 1'b1;
      data  = 8'h42;
      step();
      flush = 1'b0;
      valid = 1'b0;
      chk("flush_valid", 32'(bus.valid_o), 32'd0);
      chk("flush_ready", 32'(bus.ready_o), 32'd1);
      chk("flush_count", 32'(bus.count_o), 32'd0);
      chk("flush_data", 32'(bus.data_o), 32'h40);
      rdy = 1'b1;
      repeat (3) begin
         step();
         chk("flush_silent", 32'(bus.valid_o), 32'd0);
      end
`endif

      // Random traffic; the model checks ordering, loss and duplication every cycle.
      dut_sent = 0;
      dut_recv = 0;
      for (int c = 0; c < 10000; c++) begin
         valid = 1'($urandom_range(0, 1));
         rdy   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
         data  = 8'($urandom);
`ifdef SKID_BUFFER_FLUSH_EN
         flush = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
`endif
         step();
      end
      flush = 1'b0;
      valid = 1'b0;
      rdy   = 1'b1;
      repeat (3) step();
`ifndef SKID_BUFFER_FLUSH_EN
      chk("beats_in_out", 32'(dut_recv), 32'(dut_sent));
`endif
      chk("final_empty", 32'(bus.count_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
